// File: rtl/s_ctrl_nbuf.sv
// s_ctrl_nbuf: N-slot source ring controller for the compute core.
// Tracks NUM_BUF source slots as a ring with per-slot fill and "last job" flags.
// Starts compute on the oldest full slot (s_init) and hands results to dst
// when the downstream is ready (s_fin_in).
// Optional feature: define S_CTRL_STALL_CNT_EN to count HOLD cycles in stall_cnt;
// without it stall_cnt is tied to zero.
module s_ctrl_nbuf #(
  parameter int NUM_BUF = 2,
  parameter int CNT_W   = 16,
  localparam int SW     = (NUM_BUF > 2) ? $clog2(NUM_BUF) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               src_fin,
  input  logic               src_last,
  input  logic               s_fin,
  input  logic               dst_ready,
  output logic               s_init,
  output logic               s_fin_in,
  output logic [SW-1:0]      rd_slot,
  output logic [SW-1:0]      wr_slot,
  output logic               src_ready,
  output logic [NUM_BUF-1:0] slot_full,
  output logic               done,
  output logic               ovf_err,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Controller states
  localparam logic [1:0] ST_WAIT_SRC = 2'd0;
  localparam logic [1:0] ST_COMPUTE  = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // Highest slot index; ring pointers wrap explicitly so NUM_BUF need not be 2^n
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_BUF - 1);
  localparam logic [SW-1:0] ONE_SLOT  = SW'(1);

  logic [1:0]         state_reg, state_next;
  logic [SW-1:0]      rd_slot_reg, rd_slot_next;
  logic [SW-1:0]      wr_slot_reg, wr_slot_next;
  logic [SW-1:0]      rd_slot_inc, wr_slot_inc;
  logic [NUM_BUF-1:0] slot_full_reg, slot_full_next;
  logic [NUM_BUF-1:0] slot_last_reg, slot_last_next;
  logic               s_init_reg, s_init_next;
  logic               src_ready_reg, src_ready_next;
  logic               ovf_err_reg, ovf_err_next;

  logic               src_accept;
  logic               in_job;
  logic               cur_last;
  logic               nxt_full;
  logic               handoff;
  logic               start_job;

  // Ring pointer successors with explicit wrap
  assign rd_slot_inc = (rd_slot_reg == LAST_SLOT) ? '0 : rd_slot_reg + ONE_SLOT;
  assign wr_slot_inc = (wr_slot_reg == LAST_SLOT) ? '0 : wr_slot_reg + ONE_SLOT;

  // A write is only taken when a slot is free; otherwise it is an overflow
  assign src_accept = src_fin & src_ready_reg;

  assign in_job   = (state_reg == ST_COMPUTE) | (state_reg == ST_HOLD);
  assign cur_last = slot_last_reg[rd_slot_reg];
  assign nxt_full = slot_full_reg[rd_slot_inc];

  // Hand a result to dst only when something can follow it: either the next
  // slot already holds a job, or the current job is the final one.
  assign handoff = in_job
                 & (s_fin | (state_reg == ST_HOLD))
                 & dst_ready
                 & (nxt_full | cur_last);

  assign start_job = (state_reg == ST_WAIT_SRC) & slot_full_reg[rd_slot_reg];

  // Per-slot flag update: hand-off frees the read slot, an accepted write
  // fills the write slot. Both can happen in one cycle on different slots.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUF; gi++) begin : g_slot
      logic set_hit;
      logic clr_hit;

      assign set_hit = src_accept & (wr_slot_reg == SW'(gi));
      assign clr_hit = handoff & (rd_slot_reg == SW'(gi));

      assign slot_full_next[gi] = clr_hit ? 1'b0 :
                                  set_hit ? 1'b1 : slot_full_reg[gi];
      assign slot_last_next[gi] = clr_hit ? 1'b0 :
                                  set_hit ? src_last : slot_last_reg[gi];
    end
  endgenerate

  // Next-state and s_init trigger decode
  always_comb begin
    state_next  = state_reg;
    s_init_next = 1'b0;
    case (state_reg)
      ST_WAIT_SRC: begin
        if (start_job) begin
          state_next  = ST_COMPUTE;
          s_init_next = 1'b1;
        end
      end
      ST_COMPUTE, ST_HOLD: begin
        if (handoff) begin
          if (cur_last) begin
            state_next = ST_DONE;
          end else begin
            state_next  = ST_COMPUTE;
            s_init_next = 1'b1;
          end
        end else if (s_fin && (state_reg == ST_COMPUTE)) begin
          // Result ready but cannot be handed off yet: park it
          state_next = ST_HOLD;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_WAIT_SRC;
      end
    endcase
  end

  // Pointer, error and ready decode
  always_comb begin
    rd_slot_next   = handoff ? rd_slot_inc : rd_slot_reg;
    wr_slot_next   = src_accept ? wr_slot_inc : wr_slot_reg;
    ovf_err_next   = ovf_err_reg | (src_fin & ~src_ready_reg);
    // Registered so a slot freed this cycle shows up as ready next cycle
    src_ready_next = run & ~(&slot_full_next) & (state_next != ST_DONE);
  end

  // Controller state registers; run low clears like reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_WAIT_SRC;
      rd_slot_reg   <= '0;
      wr_slot_reg   <= '0;
      slot_full_reg <= '0;
      slot_last_reg <= '0;
      s_init_reg    <= 1'b0;
      src_ready_reg <= 1'b0;
      ovf_err_reg   <= 1'b0;
    end else if (!run) begin
      state_reg     <= ST_WAIT_SRC;
      rd_slot_reg   <= '0;
      wr_slot_reg   <= '0;
      slot_full_reg <= '0;
      slot_last_reg <= '0;
      s_init_reg    <= 1'b0;
      src_ready_reg <= 1'b0;
      ovf_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rd_slot_reg   <= rd_slot_next;
      wr_slot_reg   <= wr_slot_next;
      slot_full_reg <= slot_full_next;
      slot_last_reg <= slot_last_next;
      s_init_reg    <= s_init_next;
      src_ready_reg <= src_ready_next;
      ovf_err_reg   <= ovf_err_next;
    end
  end

`ifdef S_CTRL_STALL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_reg;

  // Count cycles spent parked in HOLD, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (!run) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == ST_HOLD) && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

  assign s_init    = s_init_reg;
  assign s_fin_in  = handoff;
  assign rd_slot   = rd_slot_reg;
  assign wr_slot   = wr_slot_reg;
  assign src_ready = src_ready_reg;
  assign slot_full = slot_full_reg;
  assign done      = (state_reg == ST_DONE);
  assign ovf_err   = ovf_err_reg;

endmodule

// File: tb/tb_s_ctrl_nbuf.sv
// Testbench for s_ctrl_nbuf (NUM_BUF=3, CNT_W=4): directed scenarios with
// literal expectations plus randomized traffic, all checked every cycle
// against a job-queue model of the slot ring.
module tb_s_ctrl_nbuf;
  localparam int NB  = 3;
  localparam int CW  = 4;
  localparam int SWB = 2;
  localparam int STALL_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b1;
  logic src_fin = 1'b0;
  logic src_last = 1'b0;
  logic s_fin = 1'b0;
  logic dst_ready = 1'b0;
  logic s_init, s_fin_in, src_ready, done, ovf_err;
  logic [SWB-1:0] rd_slot, wr_slot;
  logic [NB-1:0]  slot_full;
  logic [CW-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  bit prev_sinit = 1'b0;

  always #5 clk = ~clk;

  s_ctrl_nbuf #(.NUM_BUF(NB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .src_fin(src_fin), .src_last(src_last),
    .s_fin(s_fin), .dst_ready(dst_ready), .s_init(s_init), .s_fin_in(s_fin_in),
    .rd_slot(rd_slot), .wr_slot(wr_slot), .src_ready(src_ready),
    .slot_full(slot_full), .done(done), .ovf_err(ovf_err), .stall_cnt(stall_cnt)
  );

  // ---------------- reference model ----------------
  // Jobs waiting or in compute, oldest first; entry = its "last" tag.
  bit mq[$];
  int m_rd    = 0;
  bit m_busy  = 1'b0;   // a job is in compute or parked awaiting hand-off
  bit m_held  = 1'b0;   // result parked
  bit m_fin   = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_sinit = 1'b0;
  bit m_srdy  = 1'b0;
  int m_stall = 0;

  function automatic bit m_handoff();
    if (!m_busy || mq.size() == 0) return 1'b0;
    return (s_fin || m_held) && dst_ready && (mq.size() >= 2 || mq[0]);
  endfunction

  function automatic int m_full_vec();
    int v = 0;
    for (int k = 0; k < mq.size(); k++) v |= (1 << ((m_rd + k) % NB));
    return v;
  endfunction

  task automatic m_clear();
    mq.delete();
    m_rd = 0; m_busy = 0; m_held = 0; m_fin = 0;
    m_ovf = 0; m_sinit = 0; m_srdy = 0; m_stall = 0;
  endtask

  task automatic m_step();
    bit hf, acc, lst;
    int sz0;
    hf  = m_handoff();
    acc = src_fin && m_srdy;
    sz0 = mq.size();
    if (!run) begin
      m_clear();
      return;
    end
    m_sinit = 1'b0;
    if (src_fin && !m_srdy) m_ovf = 1'b1;
`ifdef S_CTRL_STALL_CNT_EN
    if (m_held && m_stall < STALL_MAX) m_stall++;
`endif
    if (!m_busy && !m_fin) begin
      if (sz0 > 0) begin
        m_busy  = 1'b1;
        m_sinit = 1'b1;
      end
    end else if (m_busy) begin
      if (hf) begin
        lst    = mq.pop_front();
        m_rd   = (m_rd + 1) % NB;
        m_held = 1'b0;
        if (lst) begin
          m_busy = 1'b0;
          m_fin  = 1'b1;
        end else begin
          m_sinit = 1'b1;
        end
      end else if (s_fin && !m_held) begin
        m_held = 1'b1;
      end
    end
    if (acc) mq.push_back(src_last);
    m_srdy = (mq.size() < NB) && !m_fin;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_clear();
    else     m_step();
  end

  // ---------------- checking helpers ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("s_init",    int'(s_init),    int'(m_sinit));
    chk("s_fin_in",  int'(s_fin_in),  int'(m_handoff()));
    chk("rd_slot",   int'(rd_slot),   m_rd);
    chk("wr_slot",   int'(wr_slot),   (m_rd + mq.size()) % NB);
    chk("src_ready", int'(src_ready), int'(m_srdy));
    chk("slot_full", int'(slot_full), m_full_vec());
    chk("done",      int'(done),      int'(m_fin));
    chk("ovf_err",   int'(ovf_err),   int'(m_ovf));
    chk("stall_cnt", int'(stall_cnt), m_stall);
    if (prev_sinit) chk("s_init_gap", int'(s_init), 0);
    prev_sinit = s_init;
  endtask

  task automatic drive(bit sf, bit sl, bit fn, bit dr);
    src_fin = sf; src_last = sl; s_fin = fn; dst_ready = dr;
  endtask

  task automatic half();
    @(negedge clk);
    check_all();
  endtask

  task automatic fin_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half();
    fin_cyc();
  endtask

  task automatic all_zero(string tag);
    chk({tag, "_s_init"},    int'(s_init), 0);
    chk({tag, "_s_fin_in"},  int'(s_fin_in), 0);
    chk({tag, "_rd"},        int'(rd_slot), 0);
    chk({tag, "_wr"},        int'(wr_slot), 0);
    chk({tag, "_src_ready"}, int'(src_ready), 0);
    chk({tag, "_full"},      int'(slot_full), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_ovf"},       int'(ovf_err), 0);
    chk({tag, "_stall"},     int'(stall_cnt), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b1;
    drive(0, 0, 0, 0);
    half();
    all_zero("rst");
    fin_cyc();
    rst = 1'b0;
    cyc();   // src_ready becomes visible after the first running edge
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent, inits, cd, prev_wr;
    bit saw_wrap, fn, sf;
    int rd_seq[5];

    @(posedge clk); #1;
    do_reset();

    // T1: s_fin with next slot empty parks in HOLD; filling it releases the result
    drive(1, 0, 0, 0); half(); chk("t1_srdy", int'(src_ready), 1); fin_cyc();
    drive(0, 0, 0, 0); half(); chk("t1_full0", int'(slot_full), 1);
    chk("t1_wr1", int'(wr_slot), 1); chk("t1_noinit", int'(s_init), 0); fin_cyc();
    half(); chk("t1_sinit", int'(s_init), 1); chk("t1_rd0", int'(rd_slot), 0); fin_cyc();
    drive(0, 0, 1, 1); half(); chk("t1_no_handoff", int'(s_fin_in), 0); fin_cyc();
    drive(1, 0, 0, 1); half(); chk("t1_hold_wait", int'(s_fin_in), 0); fin_cyc();
    drive(0, 0, 0, 1); half(); chk("t1_handoff", int'(s_fin_in), 1);
    chk("t1_full011", int'(slot_full), 3); fin_cyc();
    drive(0, 0, 0, 0); half(); chk("t1_sinit2", int'(s_init), 1);
    chk("t1_rd1", int'(rd_slot), 1); chk("t1_full010", int'(slot_full), 2); fin_cyc();

    // T2: single final job -> done, no further s_init
    do_reset();
    drive(1, 1, 0, 0); cyc();
    drive(0, 0, 0, 0); cyc();
    half(); chk("t2_sinit", int'(s_init), 1); fin_cyc();
    cyc();
    drive(0, 0, 1, 1); half(); chk("t2_handoff", int'(s_fin_in), 1); fin_cyc();
    drive(0, 0, 0, 0); half(); chk("t2_done", int'(done), 1);
    chk("t2_srdy", int'(src_ready), 0); chk("t2_noinit", int'(s_init), 0);
    chk("t2_rd1", int'(rd_slot), 1); fin_cyc();
    drive(0, 0, 1, 1); half(); chk("t2_sfin_ignored", int'(s_fin_in), 0); fin_cyc();

    // T3: fill all three slots, then overflow
    do_reset();
    repeat (3) begin drive(1, 0, 0, 0); cyc(); end
    drive(1, 0, 0, 0); half(); chk("t3_srdy0", int'(src_ready), 0); fin_cyc();
    drive(0, 0, 0, 0); half(); chk("t3_ovf", int'(ovf_err), 1);
    chk("t3_full111", int'(slot_full), 7); chk("t3_wr_wrap", int'(wr_slot), 0); fin_cyc();

    // T4: five jobs through the ring
    do_reset();
    sent = 0; inits = 0; cd = -1; prev_wr = 0; saw_wrap = 0;
    for (int i = 0; i < 120 && !done; i++) begin
      sf = (sent < 5) && src_ready;
      fn = (cd == 0) && !s_init;
      drive(sf, sent == 4, fn, 1);
      half();
      if (fn) cd = -1;
      else if (cd > 0) cd--;
      if (s_init) begin
        if (inits < 5) rd_seq[inits] = rd_slot;
        inits++;
        cd = 2;
      end
      if (prev_wr == 2 && wr_slot == 0) saw_wrap = 1;
      prev_wr = wr_slot;
      if (sf) sent++;
      fin_cyc();
    end
    chk("t4_inits", inits, 5);
    chk("t4_rd0", rd_seq[0], 0); chk("t4_rd1", rd_seq[1], 1);
    chk("t4_rd2", rd_seq[2], 2); chk("t4_rd3", rd_seq[3], 0);
    chk("t4_rd4", rd_seq[4], 1);
    chk("t4_wrap", int'(saw_wrap), 1);
    chk("t4_done", int'(done), 1);

    // T5: dst_ready low for 7 cycles starting at s_fin
    do_reset();
    drive(1, 0, 0, 0); cyc();
    drive(1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0); half(); chk("t5_sinit", int'(s_init), 1); fin_cyc();
    drive(0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0); repeat (6) cyc();
    drive(0, 0, 0, 1); half(); chk("t5_handoff", int'(s_fin_in), 1); fin_cyc();
    drive(0, 0, 0, 0); half();
`ifdef S_CTRL_STALL_CNT_EN
    chk("t5_stall", int'(stall_cnt), 7);
`else
    chk("t5_stall", int'(stall_cnt), 0);
`endif
    chk("t5_sinit2", int'(s_init), 1); fin_cyc();

    // T6a: asynchronous reset during COMPUTE
    do_reset();
    drive(1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0); cyc();
    half(); chk("t6_sinit", int'(s_init), 1); fin_cyc();
    drive(1, 0, 1, 1);
    @(negedge clk); check_all();
    #2 rst = 1'b1;
    #1 all_zero("t6_async");
    fin_cyc();
    rst = 1'b0;
    drive(0, 0, 0, 0); cyc();

    // T6b: run low for one cycle while parked in HOLD
    drive(1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0); cyc();
    cyc();
    drive(0, 0, 1, 0); cyc();
    drive(1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0); run = 1'b0; cyc(); run = 1'b1;
    half(); chk("t6_rd0", int'(rd_slot), 0); chk("t6_wr0", int'(wr_slot), 0);
    chk("t6_full0", int'(slot_full), 0); chk("t6_srdy0", int'(src_ready), 0);
    chk("t6_stall0", int'(stall_cnt), 0); fin_cyc();
    drive(1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0); cyc();
    half(); chk("t6_restart_init", int'(s_init), 1); chk("t6_restart_rd", int'(rd_slot), 0); fin_cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      run = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 1), $urandom_range(0, 5) == 0,
            ($urandom_range(0, 9) < 3) && !s_init, $urandom_range(0, 9) < 6);
      cyc();
      rst = 1'b0;
    end
    run = 1'b1;
    drive(0, 0, 0, 0); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
